timer_sink: RTL and testbench

- Consumer end of the timer sample stream. Accepts `t_valid`/`t_out`-style 16-bit samples (one per valid cycle, no backpressure) in the same clock domain.
- Checks that each sample equals the previous sample + 1 (mod 2^16).
- Tracks lock state, counts samples, sequence errors and wrap-arounds, and holds the last value for display or debug.

---
 rtl/timer_sink.sv | 153 +++++++++++++++
 tb/tb_timer_sink.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/timer_sink.sv
// timer_sink: consumer end of a timer sample stream.
// Checks each sample is the previous one + 1 (mod 2^DATA_W) and tracks the lock state.
// Counts accepted samples, sequence errors and wrap-arounds.
//
// Ports:
//   clock_1, reset      rising-edge clock, async active-high reset
//   r_valid, r_data     sample strobe and value (no backpressure)
//   clear               synchronous clear, same effect as reset
//   last_value          last accepted sample
//   sample_count        accepted samples (saturating)
//   err_count           sequence errors (saturating)
//   wrap_count          in-sequence max->0 transitions (wrapping)
//   locked              high while in LOCKED
//   err_pulse           one-cycle pulse per sequence error
//   max_gap             longest idle run between samples (only with TIMER_SINK_GAP_EN)
//
// Optional feature macro: TIMER_SINK_GAP_EN adds the max_gap output and its gap counter.
module timer_sink #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int WRAP_W     = 8,
    parameter int RESYNC_LEN = 4
) (
    input  logic              clock_1,
    input  logic              reset,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic              clear,
    output logic [DATA_W-1:0] last_value,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              locked,
    output logic              err_pulse
`ifdef TIMER_SINK_GAP_EN
    ,
    output logic [CNT_W-1:0]  max_gap
`endif
);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        LOCKED     = 2'd1,
        RESYNC     = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DATA_MAX  = '1;
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1);
    localparam logic [3:0]        RLEN      = 4'(RESYNC_LEN);

    state_t            state;
    logic [DATA_W-1:0] expected;
    logic [3:0]        resync_cnt;
    logic              match;
    logic              is_wrap;

    assign match   = (r_data == expected);
    // Only meaningful when the sample also matches; the wrap is an in-sequence max->0 step.
    assign is_wrap = (last_value == DATA_MAX) && (r_data == '0);

    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            state        <= WAIT_FIRST;
            expected     <= '0;
            last_value   <= '0;
            sample_count <= '0;
            err_count    <= '0;
            wrap_count   <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            resync_cnt   <= '0;
        end else if (clear) begin
            // clear wins over a coincident sample; that sample is dropped
            state        <= WAIT_FIRST;
            expected     <= '0;
            last_value   <= '0;
            sample_count <= '0;
            err_count    <= '0;
            wrap_count   <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            resync_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (r_valid) begin
                last_value <= r_data;
                expected   <= r_data + DATA_ONE;
                if (sample_count != '1) sample_count <= sample_count + CNT_ONE;
                case (state)
                    WAIT_FIRST: begin
                        state      <= LOCKED;
                        locked     <= 1'b1;
                        resync_cnt <= '0;
                    end
                    LOCKED: begin
                        if (match) begin
                            if (is_wrap) wrap_count <= wrap_count + WRAP_ONE;
                        end else begin
                            state      <= RESYNC;
                            locked     <= 1'b0;
                            err_pulse  <= 1'b1;
                            resync_cnt <= '0;
                            if (err_count != '1) err_count <= err_count + CNT_ONE;
                        end
                    end
                    RESYNC: begin
                        if (match) begin
                            if (is_wrap) wrap_count <= wrap_count + WRAP_ONE;
                            if (resync_cnt + 4'd1 == RLEN) begin
                                state      <= LOCKED;
                                locked     <= 1'b1;
                                resync_cnt <= '0;
                            end else begin
                                resync_cnt <= resync_cnt + 4'd1;
                            end
                        end else begin
                            resync_cnt <= '0;
                            err_pulse  <= 1'b1;
                            if (err_count != '1) err_count <= err_count + CNT_ONE;
                        end
                    end
                    default: begin
                        state  <= WAIT_FIRST;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TIMER_SINK_GAP_EN
    logic [CNT_W-1:0] gap;

    always_ff @(posedge clock_1 or posedge reset) begin
        if (reset) begin
            gap     <= '0;
            max_gap <= '0;
        end else if (clear) begin
            gap     <= '0;
            max_gap <= '0;
        end else if (r_valid) begin
            // the first sample has no predecessor, so its gap is not a real gap
            if (state != WAIT_FIRST && gap > max_gap) max_gap <= gap;
            gap <= '0;
        end else if (gap != '1) begin
            gap <= gap + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_timer_sink.sv
// tb_timer_sink: directed self-checking bench for timer_sink.
// Main instance uses default parameters; a second instance with CNT_W = 4
// shares the stimulus and is used for the saturation scenario.
module tb_timer_sink;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r_valid = 1'b0;
    logic [15:0] r_data = '0;
    logic        clear = 1'b0;

    logic [15:0] last_value, sample_count, err_count;
    logic [7:0]  wrap_count;
    logic        locked, err_pulse;

    logic [15:0] s_last_value;
    logic [3:0]  s_sample_count, s_err_count;
    logic [7:0]  s_wrap_count;
    logic        s_locked, s_err_pulse;

`ifdef TIMER_SINK_GAP_EN
    logic [15:0] max_gap;
    logic [3:0]  s_max_gap;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    timer_sink dut (
        .clock_1(clk), .reset(reset), .r_valid(r_valid), .r_data(r_data), .clear(clear),
        .last_value(last_value), .sample_count(sample_count), .err_count(err_count),
        .wrap_count(wrap_count), .locked(locked), .err_pulse(err_pulse)
`ifdef TIMER_SINK_GAP_EN
        , .max_gap(max_gap)
`endif
    );

    timer_sink #(.CNT_W(4)) dut_sat (
        .clock_1(clk), .reset(reset), .r_valid(r_valid), .r_data(r_data), .clear(clear),
        .last_value(s_last_value), .sample_count(s_sample_count), .err_count(s_err_count),
        .wrap_count(s_wrap_count), .locked(s_locked), .err_pulse(s_err_pulse)
`ifdef TIMER_SINK_GAP_EN
        , .max_gap(s_max_gap)
`endif
    );

    // Drive one cycle of stimulus, let the edge take it, look 1 time unit later.
    task automatic step(input logic v, input logic [15:0] d, input logic c);
        r_valid = v; r_data = d; clear = c;
        @(posedge clk); #1;
        r_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        r_valid = 1'b0; clear = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // put some state in first so reset actually has something to clear
        do_reset();
        step(1, 16'h0010, 0); step(1, 16'h0030, 0);
        reset = 1'b1; #1;
        checks++; if (last_value !== 16'h0) begin failures++; $display("FAIL reset_last got=%0h want=0", last_value); end
        checks++; if (sample_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%0d want=0", sample_count); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err got=%0d want=0", err_count); end
        checks++; if (wrap_count !== 8'h0) begin failures++; $display("FAIL reset_wrap got=%0d want=0", wrap_count); end
        checks++; if ({locked, err_pulse} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {locked, err_pulse}); end
        @(posedge clk); #1; reset = 1'b0;
        // next sample after release is a first sample: no error even though it is out of sequence
        step(1, 16'h0099, 0);
        checks++; if ({locked, err_pulse} !== 2'b10) begin failures++; $display("FAIL reset_first got=%b want=10", {locked, err_pulse}); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 16'(i), 0);
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL basic_locked i=%0d got=%b want=1", i, locked); end
        end
        checks++; if (sample_count !== 16'd5) begin failures++; $display("FAIL basic_count got=%0d want=5", sample_count); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL basic_err got=%0d want=0", err_count); end
        checks++; if (last_value !== 16'd4) begin failures++; $display("FAIL basic_last got=%0d want=4", last_value); end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        do_reset();
        d = 16'hFFFD;
        for (int i = 0; i < 5; i++) begin
            step(1, d, 0);
            d = d + 16'd1;
        end
        checks++; if (wrap_count !== 8'd1) begin failures++; $display("FAIL wrap_count got=%0d want=1", wrap_count); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL wrap_err got=%0d want=0", err_count); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL wrap_locked got=%b want=1", locked); end
        checks++; if (last_value !== 16'h0001) begin failures++; $display("FAIL wrap_last got=%0h want=1", last_value); end
    endtask

    task automatic test_resync();
        logic [15:0] seq [7];
        logic        exp_lock [7];
        logic        exp_pulse [7];
        seq       = '{16'd10, 16'd11, 16'd20, 16'd21, 16'd22, 16'd23, 16'd24};
        exp_lock  = '{1, 1, 0, 0, 0, 0, 1};
        exp_pulse = '{0, 0, 1, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1, seq[i], 0);
            checks++; if (locked !== exp_lock[i]) begin failures++; $display("FAIL resync_locked d=%0d got=%b want=%b", seq[i], locked, exp_lock[i]); end
            checks++; if (err_pulse !== exp_pulse[i]) begin failures++; $display("FAIL resync_pulse d=%0d got=%b want=%b", seq[i], err_pulse, exp_pulse[i]); end
        end
        checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL resync_err got=%0d want=1", err_count); end
    endtask

    task automatic test_back_to_back();
        // a second error inside RESYNC must restart the in-sequence run
        logic [15:0] seq [9];
        logic        exp_lock [9];
        seq      = '{16'd10, 16'd20, 16'd21, 16'd22, 16'd30, 16'd31, 16'd32, 16'd33, 16'd34};
        exp_lock = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, seq[i], 0);
            checks++; if (locked !== exp_lock[i]) begin failures++; $display("FAIL b2b_locked d=%0d got=%b want=%b", seq[i], locked, exp_lock[i]); end
        end
        checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL b2b_err got=%0d want=2", err_count); end
    endtask

    task automatic test_clear();
        do_reset();
        step(1, 16'd5, 0); step(1, 16'd6, 0);
        step(1, 16'd7, 1);
        checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL clear_count got=%0d want=0", sample_count); end
        checks++; if (last_value !== 16'd0) begin failures++; $display("FAIL clear_last got=%0d want=0", last_value); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL clear_locked got=%b want=0", locked); end
        step(1, 16'd50, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clear_relock got=%b want=1", locked); end
        checks++; if (sample_count !== 16'd1) begin failures++; $display("FAIL clear_count2 got=%0d want=1", sample_count); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clear_err got=%0d want=0", err_count); end
        checks++; if (last_value !== 16'd50) begin failures++; $display("FAIL clear_last2 got=%0d want=50", last_value); end
    endtask

    task automatic test_gap();
        do_reset();
        step(1, 16'd1, 0);
        step(0, 16'hDEAD, 0); step(0, 16'hBEEF, 0); step(0, 16'h1234, 0);
        step(1, 16'd2, 0);
        step(1, 16'd3, 0);
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL gap_err got=%0d want=0", err_count); end
        checks++; if (sample_count !== 16'd3) begin failures++; $display("FAIL gap_count got=%0d want=3", sample_count); end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap_locked got=%b want=1", locked); end
`ifdef TIMER_SINK_GAP_EN
        checks++; if (max_gap !== 16'd3) begin failures++; $display("FAIL gap_max got=%0d want=3", max_gap); end
`endif
    endtask

    task automatic test_saturation();
        logic [3:0] exp_err;
        do_reset();
        step(1, 16'd0, 0);
        // holding the same value is a mismatch every time
        for (int i = 0; i < 16; i++) begin
            step(1, 16'd0, 0);
            exp_err = (i < 15) ? 4'(i + 1) : 4'd15;
            checks++; if (s_err_pulse !== 1'b1) begin failures++; $display("FAIL sat_pulse i=%0d got=%b want=1", i, s_err_pulse); end
            checks++; if (s_err_count !== exp_err) begin failures++; $display("FAIL sat_err i=%0d got=%0d want=%0d", i, s_err_count, exp_err); end
        end
        checks++; if (s_sample_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d want=15", s_sample_count); end
        checks++; if (err_count !== 16'd16) begin failures++; $display("FAIL sat_wide_err got=%0d want=16", err_count); end
        step(0, 16'd0, 0);
        checks++; if (s_err_pulse !== 1'b0) begin failures++; $display("FAIL sat_pulse_idle got=%b want=0", s_err_pulse); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_resync();
        test_back_to_back();
        test_clear();
        test_gap();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
